styler_pixel_shifter: RTL and testbench

Downstream of the attribute styler. It accepts one styled scanline row per handshake (the styler's 16-bit bitmap output plus the cell's foreground/background colour indices) and shifts it out one pixel per pixel-rate strobe. Each pixel is tagged with its colour index. A one-row pending buffer lets the next row be loaded while the current one is shifting, so consecutive cells stream with no gap.

---
 rtl/styler_pixel_shifter.sv | 168 ++++++++++++++++
 tb/tb_styler_pixel_shifter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/styler_pixel_shifter.sv
`timescale 1ns/1ps
// styler_pixel_shifter
// Serialises one styled scanline row per handshake into a pixel stream,
// one pixel per pix_en strobe, tagging each pixel with its fg/bg colour.
// A one-row pending buffer lets the next row load while the current one
// shifts, so back-to-back rows stream with no gap.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pix_en              pixel strobe (one pixel consumed per high cycle)
//   row_in/fg/bg/valid  row bitmap + colour indices, valid strobe
//   row_ready           pending buffer empty (combinational)
//   underrun_clr        clears the sticky underrun flag
//   pix_out/color/valid current pixel bit, its colour, real-pixel flag
//   underrun            sticky: pixel requested with none available
//   busy                active shifter or pending buffer occupied
module styler_pixel_shifter #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [15:0] row_in,
  input  logic [3:0]  row_fg,
  input  logic [3:0]  row_bg,
  input  logic        row_valid,
  output logic        row_ready,
  input  logic        underrun_clr,
  output logic        pix_out,
  output logic [3:0]  pix_color,
  output logic        pix_valid,
  output logic        underrun,
  output logic        busy
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned COL_W = 4;

  // Pending buffer
  logic [WIDTH-1:0] r_pend_bits, w_pend_bits;
  logic [COL_W-1:0] r_pend_fg, w_pend_fg;
  logic [COL_W-1:0] r_pend_bg, w_pend_bg;
  logic             r_pend_full, w_pend_full;

  // Active shift register
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [COL_W-1:0] r_act_fg, w_act_fg;
  logic [COL_W-1:0] r_act_bg, w_act_bg;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic             r_armed, w_armed;
  logic             r_underrun, w_underrun;
  logic             r_pix_out, w_pix_out;
  logic [COL_W-1:0] r_pix_color, w_pix_color;
  logic             r_pix_valid, w_pix_valid;

  logic             w_head;
  logic             w_empty;
  logic             w_last;
  logic             w_xfer;
  logic             w_accept;
  logic             w_underrun_set;

  assign row_ready = rst_n & ~r_pend_full;

  // Next-state: emit, transfer pending->active, accept, underrun tracking
  always_comb begin
    w_pend_bits    = r_pend_bits;
    w_pend_fg      = r_pend_fg;
    w_pend_bg      = r_pend_bg;
    w_pend_full    = r_pend_full;
    w_shift        = r_shift;
    w_act_fg       = r_act_fg;
    w_act_bg       = r_act_bg;
    w_cnt          = r_cnt;
    w_armed        = r_armed;
    w_pix_out      = r_pix_out;
    w_pix_color    = r_pix_color;
    w_pix_valid    = r_pix_valid;

    w_head         = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    w_empty        = (r_cnt == '0);
    w_last         = (r_cnt == CNT_W'(1));
    w_underrun_set = pix_en & w_empty & r_armed;
    // Pending may move in when idle, or on the edge that emits the last pixel
    w_xfer         = r_pend_full & (w_empty | (pix_en & w_last));
    w_accept       = row_valid & row_ready;

    if (pix_en) begin
      if (!w_empty) begin
        w_pix_out   = w_head;
        w_pix_color = w_head ? r_act_fg : r_act_bg;
        w_pix_valid = 1'b1;
        if (MSB_FIRST) begin
          w_shift = r_shift << 1;
        end else begin
          w_shift = r_shift >> 1;
        end
        w_cnt = r_cnt - CNT_W'(1);
      end else begin
        w_pix_out   = 1'b0;
        w_pix_color = '0;
        w_pix_valid = 1'b0;
      end
    end

    if (w_xfer) begin
      w_shift     = r_pend_bits;
      w_act_fg    = r_pend_fg;
      w_act_bg    = r_pend_bg;
      w_cnt       = CNT_W'(WIDTH);
      w_pend_full = 1'b0;
    end

    // Accept never coincides with a transfer: row_ready is low while full
    if (w_accept) begin
      w_pend_bits = row_in[WIDTH-1:0];
      w_pend_fg   = row_fg;
      w_pend_bg   = row_bg;
      w_pend_full = 1'b1;
      w_armed     = 1'b1;
    end

    // Set wins over clear
    w_underrun = w_underrun_set | (r_underrun & ~underrun_clr);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_bits <= '0;
      r_pend_fg   <= '0;
      r_pend_bg   <= '0;
      r_pend_full <= 1'b0;
      r_shift     <= '0;
      r_act_fg    <= '0;
      r_act_bg    <= '0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_underrun  <= 1'b0;
      r_pix_out   <= 1'b0;
      r_pix_color <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pend_bits <= w_pend_bits;
      r_pend_fg   <= w_pend_fg;
      r_pend_bg   <= w_pend_bg;
      r_pend_full <= w_pend_full;
      r_shift     <= w_shift;
      r_act_fg    <= w_act_fg;
      r_act_bg    <= w_act_bg;
      r_cnt       <= w_cnt;
      r_armed     <= w_armed;
      r_underrun  <= w_underrun;
      r_pix_out   <= w_pix_out;
      r_pix_color <= w_pix_color;
      r_pix_valid <= w_pix_valid;
    end
  end

  assign pix_out   = r_pix_out;
  assign pix_color = r_pix_color;
  assign pix_valid = r_pix_valid;
  assign underrun  = r_underrun;
  assign busy      = ~w_empty | r_pend_full;

endmodule

// File: tb/tb_styler_pixel_shifter.sv
`timescale 1ns/1ps
// Bench for styler_pixel_shifter: an MSB-first and an LSB-first instance
// share all inputs; a queue-based pixel model predicts both each cycle.
module tb_styler_pixel_shifter;

  logic        clk = 1'b0;
  logic        rst_n, pix_en, row_valid, underrun_clr;
  logic [15:0] row_in;
  logic [3:0]  row_fg, row_bg;

  logic       rdy0, out0, val0, und0, busy0;
  logic [3:0] col0;
  logic       rdy1, out1, val1, und1, busy1;
  logic [3:0] col1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  styler_pixel_shifter #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .row_in(row_in),
    .row_fg(row_fg), .row_bg(row_bg), .row_valid(row_valid),
    .row_ready(rdy0), .underrun_clr(underrun_clr), .pix_out(out0),
    .pix_color(col0), .pix_valid(val0), .underrun(und0), .busy(busy0)
  );

  styler_pixel_shifter #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .row_in(row_in),
    .row_fg(row_fg), .row_bg(row_bg), .row_valid(row_valid),
    .row_ready(rdy1), .underrun_clr(underrun_clr), .pix_out(out1),
    .pix_color(col1), .pix_valid(val1), .underrun(und1), .busy(busy1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each pixel is {bit, colour}; both instances hold the same row
  // count at all times, only the pixel order differs.
  logic [4:0]  qm[$];
  logic [4:0]  ql[$];
  logic [15:0] m_pbits;
  logic [3:0]  m_pfg, m_pbg;
  bit          m_pfull = 0, m_armed = 0, m_und = 0, m_val = 0;
  logic [4:0]  m_pm = '0, m_pl = '0;
  bit          started = 0;

  always @(posedge clk) begin
    bit ready_now, und_set;
    logic b;
    started = 1;
    if (!rst_n) begin
      qm.delete(); ql.delete();
      m_pfull = 0; m_armed = 0; m_und = 0; m_val = 0;
      m_pm = '0; m_pl = '0;
    end else begin
      ready_now = !m_pfull;
      und_set = 0;
      if (pix_en) begin
        if (qm.size() > 0) begin
          m_pm = qm.pop_front(); m_pl = ql.pop_front(); m_val = 1;
        end else begin
          m_pm = '0; m_pl = '0; m_val = 0;
          und_set = m_armed;
        end
      end
      if (und_set) m_und = 1;
      else if (underrun_clr) m_und = 0;
      if (m_pfull && qm.size() == 0) begin
        for (int i = 0; i < 16; i++) begin
          b = m_pbits[15-i];
          qm.push_back({b, b ? m_pfg : m_pbg});
          b = m_pbits[i];
          ql.push_back({b, b ? m_pfg : m_pbg});
        end
        m_pfull = 0;
      end else if (row_valid && ready_now) begin
        m_pbits = row_in; m_pfg = row_fg; m_pbg = row_bg;
        m_pfull = 1; m_armed = 1;
      end
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("row_ready_m", rdy0, int'(rst_n && !m_pfull));
      chk("row_ready_l", rdy1, int'(rst_n && !m_pfull));
      chk("pix_out_m", out0, m_pm[4]);
      chk("pix_color_m", col0, m_pm[3:0]);
      chk("pix_out_l", out1, m_pl[4]);
      chk("pix_color_l", col1, m_pl[3:0]);
      chk("pix_valid_m", val0, m_val);
      chk("pix_valid_l", val1, m_val);
      chk("underrun_m", und0, m_und);
      chk("underrun_l", und1, m_und);
      chk("busy_m", busy0, int'(qm.size() != 0 || m_pfull));
      chk("busy_l", busy1, int'(ql.size() != 0 || m_pfull));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a row and hold it until accepted (bounded)
  task automatic send_row(input logic [15:0] b, input logic [3:0] fg, input logic [3:0] bg);
    bit done;
    done = 0;
    row_in = b; row_fg = fg; row_bg = bg; row_valid = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (rdy0) done = 1;
      tick();
    end
    row_valid = 0;
    chk("send_accepted", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap0, cap1;
    int n;
    rst_n = 0; pix_en = 0; row_valid = 0; underrun_clr = 0;
    row_in = '0; row_fg = '0; row_bg = '0;
    tick(); tick();
    chk("reset_ready", rdy0, 0);
    chk("reset_valid", val0, 0);
    rst_n = 1;
    #1;
    chk("ready_after_release", rdy0, 1);
    tick();

    // Strobes before any row: no pixel, not armed
    pix_en = 1;
    repeat (5) tick();
    chk("unarmed_underrun", und0, 0);
    chk("unarmed_valid", val0, 0);
    pix_en = 0;

    // Single row, idle latency and bit order
    row_in = 16'hA5C3; row_fg = 4'h7; row_bg = 4'h1; row_valid = 1;
    tick();                     // edge N: accepted
    row_valid = 0;
    chk("after_accept_busy", busy0, 1);
    tick();                     // edge N+1: transfer
    chk("after_xfer_valid", val0, 0);
    pix_en = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("row1_valid", val0, 1);
      chk("row1_color", col0, out0 ? 7 : 1);
      cap0[15-i] = out0;
      cap1[i] = out1;
    end
    chk("row1_seq_msb", cap0, 16'hA5C3);
    chk("row1_seq_lsb", cap1, 16'hA5C3);

    // Underrun, and set-beats-clear
    tick();
    chk("underrun_valid", val0, 0);
    chk("underrun_color", col0, 0);
    chk("underrun_set", und0, 1);
    underrun_clr = 1;
    tick();
    chk("underrun_set_wins", und0, 1);
    pix_en = 0;
    tick();
    chk("underrun_cleared", und0, 0);
    underrun_clr = 0;

    // Back-to-back rows, no bubble
    send_row(16'hFFFF, 4'h2, 4'h0);
    send_row(16'h0000, 4'h0, 4'h9);
    pix_en = 1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("stream_valid", val0, 1);
      chk("stream_color", col0, (i < 16) ? 2 : 9);
      chk("stream_no_underrun", und0, 0);
    end
    pix_en = 0;
    tick();

    // Reset mid-row with both buffers full
    send_row(16'h1234, 4'h3, 4'h4);
    send_row(16'h5678, 4'h5, 4'h6);
    chk("full_ready", rdy0, 0);
    chk("full_busy", busy0, 1);
    pix_en = 1;
    repeat (3) tick();
    rst_n = 0; pix_en = 0;
    tick();
    chk("rst_valid", val0, 0);
    chk("rst_out", out0, 0);
    chk("rst_color", col0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready_low", rdy0, 0);
    rst_n = 1;
    #1;
    chk("rst_ready_release", rdy0, 1);
    tick();
    chk("post_rst_busy", busy0, 0);

    // LSB-first, strobe every third cycle
    send_row(16'h0001, 4'h5, 4'h3);
    tick();                     // transfer edge
    n = 0;
    for (int i = 0; i < 60; i++) begin
      pix_en = (i % 3 == 0);
      tick();
      if (pix_en && n < 16) begin
        chk("lsb_out", out1, (n == 0) ? 1 : 0);
        chk("lsb_color", col1, (n == 0) ? 5 : 3);
        n++;
      end
    end
    chk("lsb_strobes", n, 16);
    pix_en = 0;
    underrun_clr = 1;
    tick();
    underrun_clr = 0;

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      pix_en = ($urandom_range(0, 9) < 7);
      row_valid = ($urandom_range(0, 2) == 0);
      row_in = 16'($urandom);
      row_fg = 4'($urandom);
      row_bg = 4'($urandom);
      underrun_clr = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1; pix_en = 0; row_valid = 0; underrun_clr = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
